// File: rtl/paddle_pkg.sv
// Shared types and playfield constants for the pong paddle input path.
// Owner encoding is also the arbiter's FSM state encoding.
package paddle_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_ENC  = 2'b01,
    OWN_BTN  = 2'b10
  } owner_t;

  localparam int V_RES   = 480;
  localparam int PAD_H   = 40;
  localparam int PAD_MAX = V_RES - PAD_H;

endpackage

// File: rtl/paddle_step_clamp.sv
// Moves a paddle position one step up or down, clamped to [0, MAX].
// The sum is formed one bit wider so a step past MAX cannot wrap.
module paddle_step_clamp #(
  parameter int CORDW = 10,
  parameter int MAX   = 440
) (
  input  logic [CORDW-1:0] pos,
  input  logic             dn,
  input  logic [CORDW-1:0] step,
  output logic [CORDW-1:0] nxt
);

  localparam logic [CORDW:0] MAX_W = (CORDW+1)'(MAX);

  logic [CORDW:0] sum;

  assign sum = {1'b0, pos} + {1'b0, step};

  always_comb begin
    nxt = pos;
    if (dn)
      nxt = (sum <= MAX_W) ? sum[CORDW-1:0] : MAX_W[CORDW-1:0];
    else
      nxt = (pos >= step) ? pos - step : '0;
  end

endmodule

// File: rtl/paddle_input_arb.sv
// Arbitrates encoder steps and push-buttons for the paddle y register.
// Ownership lapses after HOLD_FRAMES idle frames of the current owner.
module paddle_input_arb #(
  parameter int CORDW       = 10,
  parameter int V_RES       = paddle_pkg::V_RES,
  parameter int PAD_H       = paddle_pkg::PAD_H,
  parameter int ENC_SP      = 4,
  parameter int BTN_SP      = 2,
  parameter int HOLD_FRAMES = 30,
  parameter int START_POS   = (V_RES - PAD_H) / 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enc_up,
  input  logic             i_enc_dn,
  input  logic             i_btn_up,
  input  logic             i_btn_dn,
  input  logic             i_frame,
  output logic [CORDW-1:0] o_pos,
  output logic [1:0]       o_owner,
  output logic             o_moved
);

  import paddle_pkg::*;

  localparam int PMAX = V_RES - PAD_H;
  localparam int HW   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_FRAMES);

  owner_t           state;
  logic [HW-1:0]    hold;
  logic [CORDW-1:0] pos_q;
  logic             moved_q;

  logic             enc_req;
  logic             btn_req;
  logic             take_enc;
  logic             take_btn;
  logic             mv;
  logic             dir_dn;
  logic [CORDW-1:0] step;
  logic [CORDW-1:0] nxt;

  // Both directions at once cancel out and count as no activity.
  assign enc_req = i_enc_up ^ i_enc_dn;
  assign btn_req = i_btn_up ^ i_btn_dn;

  always_comb begin
    take_enc = 1'b0;
    take_btn = 1'b0;
    case (state)
      OWN_IDLE: begin
        take_enc = enc_req;
        take_btn = !enc_req && btn_req && i_frame;
      end
      OWN_ENC: take_enc = enc_req;
      OWN_BTN: take_btn = btn_req && i_frame;
      default: ;
    endcase
  end

  assign mv     = take_enc | take_btn;
  assign dir_dn = take_enc ? i_enc_dn : i_btn_dn;
  assign step   = take_enc ? CORDW'(ENC_SP) : CORDW'(BTN_SP);

  paddle_step_clamp #(
    .CORDW (CORDW),
    .MAX   (PMAX)
  ) u_clamp (
    .pos  (pos_q),
    .dn   (dir_dn),
    .step (step),
    .nxt  (nxt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= OWN_IDLE;
      pos_q   <= CORDW'(START_POS);
      hold    <= '0;
      moved_q <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      if (mv) begin
        pos_q   <= nxt;
        moved_q <= (nxt != pos_q);
        hold    <= HOLD_LD;
        state   <= take_enc ? OWN_ENC : OWN_BTN;
      end else if (i_frame && state != OWN_IDLE) begin
        if (hold <= HW'(1)) begin
          hold  <= '0;
          state <= OWN_IDLE;
        end else begin
          hold <= hold - HW'(1);
        end
      end
    end
  end

  assign o_pos   = pos_q;
  assign o_owner = state;
  assign o_moved = moved_q;

endmodule

// File: tb/tb_paddle_input_arb.sv
// Directed bench for paddle_input_arb: vector table plus
// hand-written hold, clamp and reset sequences.
module tb_paddle_input_arb;

  import paddle_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_enc_up, i_enc_dn;
  logic       i_btn_up, i_btn_dn;
  logic       i_frame;
  logic [9:0] o_pos;
  logic [1:0] o_owner;
  logic       o_moved;

  int checks = 0;
  int errors = 0;

  paddle_input_arb dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enc_up (i_enc_up),
    .i_enc_dn (i_enc_dn),
    .i_btn_up (i_btn_up),
    .i_btn_dn (i_btn_dn),
    .i_frame  (i_frame),
    .o_pos    (o_pos),
    .o_owner  (o_owner),
    .o_moved  (o_moved)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       eu, ed, bu, bd, fr;
    logic [9:0] pos;
    owner_t     own;
    logic       mv;
    string      nm;
  } vec_t;

  vec_t tbl[8];

  task automatic cyc(input logic eu, ed, bu, bd, fr, rn);
    i_enc_up = eu;
    i_enc_dn = ed;
    i_btn_up = bu;
    i_btn_dn = bd;
    i_frame  = fr;
    i_rst_n  = rn;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] p,
                     input owner_t ow, input logic mv);
    checks++;
    if (o_pos !== p || o_owner !== 2'(ow) || o_moved !== mv) begin
      errors++;
      $display("FAIL %s: pos=%0d owner=%0d moved=%b, want pos=%0d owner=%0d moved=%b",
               nm, o_pos, o_owner, o_moved, p, ow, mv);
    end
  endtask

  // n frames of 3 cycles each, nothing expected to change
  task automatic frames(input int n, input logic bu, bd,
                        input logic [9:0] p, input owner_t ow, input string nm);
    for (int f = 0; f < n; f++) begin
      cyc(1'b0, 1'b0, bu, bd, 1'b1, 1'b1);
      chk(nm, p, ow, 1'b0);
      for (int k = 0; k < 2; k++) begin
        cyc(1'b0, 1'b0, bu, bd, 1'b0, 1'b1);
        chk(nm, p, ow, 1'b0);
      end
    end
  endtask

  logic [9:0] p;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd224, OWN_ENC, 1'b1, "enc_dn1"};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd224, OWN_ENC, 1'b0, "enc_gap"};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd228, OWN_ENC, 1'b1, "enc_dn2"};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd232, OWN_ENC, 1'b1, "enc_dn3"};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd232, OWN_ENC, 1'b0, "enc_both"};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd232, OWN_ENC, 1'b0, "btn_in_enc"};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd228, OWN_ENC, 1'b1, "enc_up_fr"};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd228, OWN_ENC, 1'b0, "btn_both"};

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset", 10'd220, OWN_IDLE, 1'b0);
    frames(100, 1'b0, 1'b0, 10'd220, OWN_IDLE, "idle100");

    foreach (tbl[i]) begin
      cyc(tbl[i].eu, tbl[i].ed, tbl[i].bu, tbl[i].bd, tbl[i].fr, 1'b1);
      chk(tbl[i].nm, tbl[i].pos, tbl[i].own, tbl[i].mv);
    end

    // hold reloaded to 30 by last move; button held is ignored
    frames(29, 1'b1, 1'b0, 10'd228, OWN_ENC, "enc_hold_btn");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("enc_release", 10'd228, OWN_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("btn_no_frame", 10'd228, OWN_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("btn_up1", 10'd226, OWN_BTN, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("btn_gap", 10'd226, OWN_BTN, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("btn_up2", 10'd224, OWN_BTN, 1'b1);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_btn", 10'd220, OWN_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst", 10'd220, OWN_IDLE, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("enc_wins", 10'd216, OWN_ENC, 1'b1);
    frames(29, 1'b0, 1'b0, 10'd216, OWN_ENC, "enc_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("enc_release2", 10'd216, OWN_IDLE, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("btn_dn", 10'd218, OWN_BTN, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("enc_in_btn", 10'd218, OWN_BTN, 1'b0);
    frames(29, 1'b0, 1'b0, 10'd218, OWN_BTN, "btn_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("btn_release", 10'd218, OWN_IDLE, 1'b0);

    p = 10'd218;
    for (int i = 0; i < 55; i++) begin
      p = p + 10'd4;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("enc_walk_dn", p, OWN_ENC, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clamp_bot", 10'd440, OWN_ENC, 1'b1);
    frames(5, 1'b0, 1'b0, 10'd440, OWN_ENC, "bot_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("at_bot", 10'd440, OWN_ENC, 1'b0);
    frames(29, 1'b0, 1'b0, 10'd440, OWN_ENC, "bot_reload");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bot_release", 10'd440, OWN_IDLE, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("btn_up_438", 10'd438, OWN_BTN, 1'b1);
    frames(29, 1'b0, 1'b0, 10'd438, OWN_BTN, "btn_hold2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("btn_release2", 10'd438, OWN_IDLE, 1'b0);

    p = 10'd438;
    for (int i = 0; i < 109; i++) begin
      p = p - 10'd4;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("enc_walk_up", p, OWN_ENC, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clamp_top", 10'd0, OWN_ENC, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("at_top", 10'd0, OWN_ENC, 1'b0);
    frames(29, 1'b0, 1'b0, 10'd0, OWN_ENC, "top_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("top_release", 10'd0, OWN_IDLE, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("btn_both_idle", 10'd0, OWN_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("btn_both_idle2", 10'd0, OWN_IDLE, 1'b0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("enc_dn_4", 10'd4, OWN_ENC, 1'b1);
    frames(29, 1'b0, 1'b0, 10'd4, OWN_ENC, "to_hold1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reload_wins", 10'd0, OWN_ENC, 1'b1);
    frames(29, 1'b0, 1'b0, 10'd0, OWN_ENC, "reloaded");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("final_release", 10'd0, OWN_IDLE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
